// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the acceptance-time legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // True when the access must be refused without touching memory:
    // unknown width, misaligned half/word, or an unsigned-width store.
    function automatic logic access_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] offset);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_BU:   err = write;
            F3_H:    err = offset[0];
            F3_HU:   err = write | offset[0];
            F3_W:    err = (offset != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response channel plus word-addressed data memory port.
// master: the load/store unit. slave: the CPU datapath and memory around it.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_dout;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_din, mem_read, mem_write
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               mem_addr, mem_din, mem_read, mem_write
    );

endinterface

// File: rtl/lsu_align.sv
// Byte/half lane steering: extracts and extends load data from a memory word,
// and merges sub-word store data into a memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed lane and extend it according to the width code
    always_comb begin
        unique case (addr)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
        endcase
        half_lane = addr[1] ? word[31:16] : word[15:0];

        unique case (funct3)
            F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {24'h0, byte_lane};
            F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_data = {16'h0, half_lane};
            F3_W:    load_data = word;
            default: load_data = 32'h0;
        endcase
    end

    // Overwrite only the addressed lanes; other lanes keep the read-back value
    always_comb begin
        store_word = word;
        if (funct3 == F3_B) begin
            unique case (addr)
                2'd0: store_word[7:0]   = wdata[7:0];
                2'd1: store_word[15:8]  = wdata[7:0];
                2'd2: store_word[23:16] = wdata[7:0];
                2'd3: store_word[31:24] = wdata[7:0];
            endcase
        end else if (funct3 == F3_H) begin
            if (addr[1]) begin
                store_word[31:16] = wdata;
            end else begin
                store_word[15:0] = wdata;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store in flight, sub-word stores done as
// read-modify-write because the memory only writes whole words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned READ_WAIT = 1
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.master  bus
);

    localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

    lsu_state_e  state_q;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;
    logic [3:0]  wait_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [31:0] load_data;
    logic [31:0] store_word;

    // Steering works on the live memory word with the captured request fields
    lsu_align u_align (
        .word       (bus.mem_dout),
        .addr       (offset_q),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Sequencer: state plus every registered output, so strobes drop on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            wdata_q      <= 16'h0;
            wait_q       <= 4'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_error_q <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_din_q    <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        write_q    <= bus.req_write;
                        funct3_q   <= bus.req_funct3;
                        offset_q   <= bus.req_addr[1:0];
                        wdata_q    <= bus.req_wdata[15:0];
                        mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                        if (access_error(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'h0;
                            resp_error_q <= 1'b1;
                        end else if (bus.req_write && bus.req_funct3 == F3_W) begin
                            // Full-word store needs no read-back
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                            mem_din_q   <= bus.req_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read
                            state_q    <= READ;
                            mem_read_q <= 1'b1;
                            wait_q     <= WAIT_INIT;
                        end
                    end
                end
                READ: begin
                    if (wait_q == 4'h0) begin
                        mem_read_q <= 1'b0;
                        if (write_q) begin
                            state_q     <= WRITE;
                            mem_write_q <= 1'b1;
                            mem_din_q   <= store_word;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= load_data;
                            resp_error_q <= 1'b0;
                        end
                    end else begin
                        wait_q <= wait_q - 4'h1;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= 32'h0;
                    resp_error_q <= 1'b0;
                end
                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Two units (READ_WAIT 1 and 3) share one request stream, each with its own
// word memory; results are checked against a table and a behavioural model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    logic [31:0] ref_mem [64];

    int n_checks = 0;
    int n_err    = 0;

    load_store_unit_if bus_a ();
    load_store_unit_if bus_b ();

    assign bus_a.req_valid  = req_valid;
    assign bus_a.req_write  = req_write;
    assign bus_a.req_addr   = req_addr;
    assign bus_a.req_wdata  = req_wdata;
    assign bus_a.req_funct3 = req_funct3;
    assign bus_a.mem_dout   = mem_a[bus_a.mem_addr[7:2]];
    assign bus_b.req_valid  = req_valid;
    assign bus_b.req_write  = req_write;
    assign bus_b.req_addr   = req_addr;
    assign bus_b.req_wdata  = req_wdata;
    assign bus_b.req_funct3 = req_funct3;
    assign bus_b.mem_dout   = mem_b[bus_b.mem_addr[7:2]];

    load_store_unit #(.READ_WAIT(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    load_store_unit #(.READ_WAIT(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            mem_a[pre_idx] <= pre_val;
            mem_b[pre_idx] <= pre_val;
        end
        if (bus_a.mem_write) mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_din;
        if (bus_b.mem_write) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_din;
    end

    // Per-transaction observations, index 0 = READ_WAIT 1, 1 = READ_WAIT 3
    int          obs_lat [2];
    int          obs_rd [2];
    int          obs_wr [2];
    int          obs_ovl [2];
    int          obs_abad [2];
    logic [31:0] obs_din [2];
    logic [31:0] obs_rdata [2];
    logic        obs_err [2];
    logic        obs_rdy [2];

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] word;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ref_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b100:  e = w;
            3'b001:  e = a[0];
            3'b101:  e = w || a[0];
            3'b010:  e = (a[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] v;
        int bsh = 8 * int'(a[1:0]);
        int hsh = 16 * int'(a[1]);
        case (f3)
            3'b000: begin v = (word >> bsh) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b100: v = (word >> bsh) & 32'hFF;
            3'b001: begin v = (word >> hsh) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b101: v = (word >> hsh) & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (f3 == 3'b010) return wd;
        if (f3 == 3'b000) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
        end
        return (word & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = 6'(idx);
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
        logic [31:0] exp_ma;
        logic        done [2];
        exp_ma = {a[31:2], 2'b00};
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            done[d] = 1'b0; obs_lat[d] = 0; obs_rd[d] = 0; obs_wr[d] = 0; obs_ovl[d] = 0;
            obs_abad[d] = 0; obs_din[d] = 32'h0; obs_rdata[d] = 32'h0; obs_err[d] = 1'b0;
            obs_rdy[d] = 1'b0;
        end
        for (int c = 1; c <= 40 && !(done[0] && done[1]); c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic rv, rs, ws, rdy, er;
                logic [31:0] rdat, ma, md;
                if (d == 0) begin
                    rv = bus_a.resp_valid; rs = bus_a.mem_read; ws = bus_a.mem_write;
                    rdy = bus_a.req_ready; er = bus_a.resp_error; rdat = bus_a.resp_rdata;
                    ma = bus_a.mem_addr; md = bus_a.mem_din;
                end else begin
                    rv = bus_b.resp_valid; rs = bus_b.mem_read; ws = bus_b.mem_write;
                    rdy = bus_b.req_ready; er = bus_b.resp_error; rdat = bus_b.resp_rdata;
                    ma = bus_b.mem_addr; md = bus_b.mem_din;
                end
                if (!done[d]) begin
                    if (rs) obs_rd[d]++;
                    if (ws) begin obs_wr[d]++; obs_din[d] = md; end
                    if (rs && ws) obs_ovl[d]++;
                    if ((rs || ws) && ma !== exp_ma) obs_abad[d]++;
                    if (rv) begin
                        done[d] = 1'b1; obs_lat[d] = c; obs_rdata[d] = rdat;
                        obs_err[d] = er; obs_rdy[d] = rdy;
                    end
                end
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic [31:0] exp_din);
        for (int d = 0; d < 2; d++) begin
            int rw;
            int e_lat, e_rd, e_wr;
            string t;
            rw = (d == 0) ? 1 : 3;
            t = $sformatf("%s/rw%0d", tag, rw);
            if (exp_err)         begin e_lat = 1;      e_rd = 0;  e_wr = 0; end
            else if (!w)         begin e_lat = rw + 1; e_rd = rw; e_wr = 0; end
            else if (f3 == F3_W) begin e_lat = 2;      e_rd = 0;  e_wr = 1; end
            else                 begin e_lat = rw + 2; e_rd = rw; e_wr = 1; end
            check({t, " latency"}, 32'(obs_lat[d]), 32'(e_lat));
            check({t, " rdata"}, obs_rdata[d], exp_rdata);
            check({t, " error"}, 32'(obs_err[d]), 32'(exp_err));
            check({t, " read_cycles"}, 32'(obs_rd[d]), 32'(e_rd));
            check({t, " write_cycles"}, 32'(obs_wr[d]), 32'(e_wr));
            if (e_wr != 0) check({t, " mem_din"}, obs_din[d], exp_din);
            check({t, " mem_addr_bad"}, 32'(obs_abad[d]), 32'h0);
            check({t, " rd_wr_overlap"}, 32'(obs_ovl[d]), 32'h0);
            check({t, " ready_in_resp"}, 32'(obs_rdy[d]), 32'h0);
        end
    endtask

    initial begin
        int mask;
        int n_resp;

        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h0,        32'h00000080, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b1, 32'h11223344, 32'h0,        1'b0, 32'h1122AB44};
        vecs[5]  = '{1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'h0,        32'h1122AB44, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h22, 32'h0000CAFE, 1'b1, 32'h55667788, 32'h0,        1'b0, 32'hCAFE7788};
        vecs[7]  = '{1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'h0,        32'hCAFE7788, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 3'b001, 32'h01, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b0, 3'b101, 32'h02, 32'h0,        1'b1, 32'h80010000, 32'h00008001, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h02, 32'h0,        1'b0, 32'h0,        32'hFFFF8001, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 3'b000, 32'h03, 32'h1234567F, 1'b0, 32'h0,        32'h0,        1'b0, 32'h7F010000};
        vecs[12] = '{1'b1, 3'b100, 32'h04, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[13] = '{1'b0, 3'b011, 32'h08, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[14] = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[15] = '{1'b1, 3'b010, 32'h08, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0, 32'h12345678};
        vecs[16] = '{1'b0, 3'b010, 32'h08, 32'h0,        1'b0, 32'h0,        32'h12345678, 1'b0, 32'h0};
        vecs[17] = '{1'b1, 3'b001, 32'h09, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};
        vecs[18] = '{1'b1, 3'b111, 32'h0C, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 32'h0};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_funct3 = 3'b000; pre_en = 1'b0; pre_idx = 6'h0; pre_val = 32'h0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus_a.req_ready), 32'h1);
        check("reset resp_valid", 32'(bus_a.resp_valid), 32'h0);
        check("reset resp_rdata", bus_a.resp_rdata, 32'h0);
        check("reset resp_error", 32'(bus_a.resp_error), 32'h0);
        check("reset mem_read", 32'(bus_a.mem_read), 32'h0);
        check("reset mem_write", 32'(bus_a.mem_write), 32'h0);
        check("reset mem_addr", bus_a.mem_addr, 32'h0);
        check("reset mem_din", bus_a.mem_din, 32'h0);
        check("reset req_ready rw3", 32'(bus_b.req_ready), 32'h1);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Directed table
        for (int i = 0; i < 19; i++) begin
            int idx;
            idx = int'(vecs[i].addr[7:2]);
            if (vecs[i].pre) preload(idx, vecs[i].word);
            run_txn(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            check_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].f3, vecs[i].exp_rdata,
                      vecs[i].exp_err, vecs[i].exp_din);
            if (vecs[i].w && !vecs[i].exp_err) ref_mem[idx] = vecs[i].exp_din;
        end

        // Back-to-back: request held valid, second accepted right after RESP
        mask = 0;
        n_resp = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        for (int c = 0; c <= 8; c++) begin
            if (c == 3) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
            @(negedge clk);
            if (bus_a.resp_valid) begin
                mask = mask | (1 << (c + 1));
                n_resp++;
                check("b2b rdata", bus_a.resp_rdata, ref_mem[4]);
            end
        end
        check("b2b resp cycles", 32'(mask), 32'((1 << 2) | (1 << 5)));
        repeat (6) @(negedge clk);

        // Reset during the WRITE cycle of a sub-word store
        preload(12, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h31;
        req_wdata = 32'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid read cycle", 32'(bus_a.mem_read), 32'h1);
        @(negedge clk);
        check("rst_mid write cycle", 32'(bus_a.mem_write), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_mid mem_write drop", 32'(bus_a.mem_write), 32'h0);
        check("rst_mid mem_read drop rw3", 32'(bus_b.mem_read), 32'h0);
        check("rst_mid mem_addr cleared", bus_a.mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid word unchanged", mem_a[12], 32'h11223344);
        check("rst_mid word unchanged rw3", mem_b[12], 32'h11223344);
        check("rst_mid req_ready", 32'(bus_a.req_ready), 32'h1);
        n_resp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_a.resp_valid || bus_b.resp_valid) n_resp++;
        end
        check("rst_mid no response", 32'(n_resp), 32'h0);

        // Randomized traffic against the behavioural model
        for (int i = 0; i < 200; i++) begin
            logic        w, e;
            logic [2:0]  f3;
            logic [31:0] a, wd, er, ed;
            int          idx;
            logic [2:0]  legal [5];
            legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
            legal[3] = 3'b100; legal[4] = 3'b101;
            w  = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 4)]
                                             : 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0 && (f3 == 3'b010)) a[1:0] = 2'b00;
            if ($urandom_range(0, 2) != 0 && (f3 == 3'b001 || f3 == 3'b101)) a[0] = 1'b0;
            wd  = $urandom;
            idx = int'(a[7:2]);
            e   = ref_err(w, f3, a);
            er  = 32'h0;
            ed  = 32'h0;
            if (!e && !w) er = ref_load(ref_mem[idx], f3, a);
            if (!e && w) ed = ref_store(ref_mem[idx], f3, a, wd);
            run_txn(w, f3, a, wd);
            check_txn($sformatf("rnd%0d", i), w, f3, er, e, ed);
            if (!e && w) ref_mem[idx] = ed;
        end

        // Final memory images must match the model word for word
        mask = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_a[i] !== ref_mem[i] || mem_b[i] !== ref_mem[i]) mask++;
        end
        check("final memory words differing", 32'(mask), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
